// File: rtl/ov7670_capture.sv
// OV7670 RGB565 byte-stream capture into a 32-bit AXI-Stream pixel stream with a 4-entry output FIFO.
// Define OV7670_CAPTURE_PROC_EN to compile in the brightness/contrast stage; otherwise pixels pass through.
module ov7670_capture (
    input  logic        m_axis_aclk,
    input  logic        m_axis_aresetn,
    input  logic        vsync,
    input  logic        href,
    input  logic [7:0]  data,
    output logic        fsync,
    output logic        m_axis_tvalid,
    output logic [31:0] m_axis_tdata,
    output logic [3:0]  m_axis_tstrb,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    input  logic [31:0] register_control,
    input  logic [31:0] register_brightness,
    input  logic [31:0] register_contrast
);

    typedef enum logic {PH_FIRST, PH_SECOND} phase_e;

    localparam int DEPTH = 4;

    logic       vsync_q, href_q, vsync_prev_q, href_prev_q;
    logic [7:0] data_q;
    logic       fsync_q, cap_en_q;
    logic       vsync_rise, href_rise, href_fall;

    assign vsync_rise = vsync_q && !vsync_prev_q;
    assign href_rise  = href_q && !href_prev_q;
    assign href_fall  = href_prev_q && !href_q;

    // NOTE: sequential state uses <= so every register sees pre-edge values regardless of block order.
    always_ff @(posedge m_axis_aclk) begin
        if (!m_axis_aresetn) begin
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            data_q       <= 8'h00;
            vsync_prev_q <= 1'b0;
            href_prev_q  <= 1'b0;
            fsync_q      <= 1'b0;
            cap_en_q     <= 1'b0;
        end else begin
            vsync_q      <= vsync;
            href_q       <= href;
            data_q       <= data;
            vsync_prev_q <= vsync_q;
            href_prev_q  <= href_q;
            fsync_q      <= vsync_rise;
            if (vsync_rise) begin
                cap_en_q <= register_control[0];
            end
        end
    end

    // Byte-phase FSM: which half of the RGB565 word the registered byte is.
    phase_e phase_q, phase_d;
    logic   take_hi, pix_done;

    always_ff @(posedge m_axis_aclk) begin
        if (!m_axis_aresetn) begin
            phase_q <= PH_FIRST;
        end else begin
            phase_q <= phase_d;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        phase_d = phase_q;
        if (take_hi) begin
            phase_d = PH_SECOND;
        end else if (pix_done || vsync_rise) begin
            phase_d = PH_FIRST;
        end
    end

    always_comb begin
        take_hi  = 1'b0;
        pix_done = 1'b0;
        if (href_q) begin
            if (href_rise || vsync_rise || phase_q == PH_FIRST) begin
                take_hi = 1'b1;
            end else begin
                pix_done = 1'b1;
            end
        end
    end

    function automatic logic [23:0] expand(input logic [15:0] p);
        return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
    endfunction

    logic [7:0]  hi_q;
    logic        pix_valid_q;
    logic [23:0] pix_q;

    always_ff @(posedge m_axis_aclk) begin
        if (!m_axis_aresetn) begin
            hi_q        <= 8'h00;
            pix_valid_q <= 1'b0;
            pix_q       <= 24'h0;
        end else begin
            if (take_hi) begin
                hi_q <= data_q;
            end
            pix_valid_q <= pix_done && cap_en_q;
            if (pix_done) begin
                pix_q <= expand({hi_q, data_q});
            end
        end
    end

    logic [23:0] proc_d, proc_q;
    logic        proc_valid_q, proc_last_q;

`ifdef OV7670_CAPTURE_PROC_EN
    function automatic logic [7:0] adjust(input logic [7:0] c, input logic [7:0] gain,
                                          input logic signed [8:0] offs);
        logic [15:0]        prod;
        logic signed [17:0] sum;
        prod = 16'(c) * 16'(gain);
        sum  = $signed({6'd0, 12'(prod >> 4)}) + 18'(offs);
        if (sum < 18'sd0) begin
            return 8'h00;
        end
        if (sum > 18'sd255) begin
            return 8'hFF;
        end
        return sum[7:0];
    endfunction

    always_comb begin
        proc_d = pix_q;
        if (register_control[5]) begin
            proc_d = {adjust(pix_q[23:16], register_contrast[7:0], register_brightness[8:0]),
                      adjust(pix_q[15:8],  register_contrast[7:0], register_brightness[8:0]),
                      adjust(pix_q[7:0],   register_contrast[7:0], register_brightness[8:0])};
        end
    end

    logic unused_cfg;
    assign unused_cfg = ^{register_control[31:6], register_control[4:1],
                          register_brightness[31:9], register_contrast[31:8]};
`else
    assign proc_d = pix_q;

    logic unused_cfg;
    assign unused_cfg = ^{register_control[31:1], register_brightness, register_contrast};
`endif

    // The href-fall marker travels alongside the pixel so the release logic sees both together.
    always_ff @(posedge m_axis_aclk) begin
        if (!m_axis_aresetn) begin
            proc_valid_q <= 1'b0;
            proc_last_q  <= 1'b0;
            proc_q       <= 24'h0;
        end else begin
            proc_valid_q <= pix_valid_q;
            proc_last_q  <= href_fall;
            proc_q       <= proc_d;
        end
    end

    logic [23:0] hold_q, hold_d;
    logic        hold_valid_q, hold_valid_d, flush_q, flush_d;
    logic        push;
    logic [24:0] push_word;

    always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        flush_d      = 1'b0;
        push         = 1'b0;
        push_word    = {1'b0, hold_q};
        if (flush_q) begin
            push         = hold_valid_q;
            push_word    = {1'b1, hold_q};
            hold_valid_d = 1'b0;
        end else if (proc_valid_q) begin
            if (hold_valid_q) begin
                push         = 1'b1;
                hold_d       = proc_q;
                hold_valid_d = 1'b1;
                flush_d      = proc_last_q;
            end else if (proc_last_q) begin
                push      = 1'b1;
                push_word = {1'b1, proc_q};
            end else begin
                hold_d       = proc_q;
                hold_valid_d = 1'b1;
            end
        end else if (proc_last_q && hold_valid_q) begin
            push         = 1'b1;
            push_word    = {1'b1, hold_q};
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge m_axis_aclk) begin
        if (!m_axis_aresetn) begin
            hold_q       <= 24'h0;
            hold_valid_q <= 1'b0;
            flush_q      <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            flush_q      <= flush_d;
        end
    end

    logic [24:0] mem_q [DEPTH];
    logic [1:0]  wr_ptr_q, rd_ptr_q;
    logic [2:0]  count_q;
    logic        empty, full, pop, push_ok;

    assign empty   = (count_q == 3'd0);
    assign full    = (count_q == 3'd4);
    assign pop     = !empty && m_axis_tready;
    assign push_ok = push && (!full || pop);

    // NOTE: FIFO storage is not reset; the outputs are qualified by the empty flag instead.
    always_ff @(posedge m_axis_aclk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    always_ff @(posedge m_axis_aclk) begin
        if (!m_axis_aresetn) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            count_q <= count_q + {2'b00, push_ok} - {2'b00, pop};
        end
    end

    assign fsync         = fsync_q;
    assign m_axis_tvalid = !empty;
    assign m_axis_tdata  = empty ? 32'h0 : {8'h00, mem_q[rd_ptr_q][23:0]};
    assign m_axis_tlast  = !empty && mem_q[rd_ptr_q][24];
    assign m_axis_tstrb  = 4'hF;

endmodule

// File: tb/tb_ov7670_capture.sv
// Bench for ov7670_capture: vector table for the pixel path, hand sequences for framing,
// reset, backpressure and long lines; AXI-Stream beats are checked against a scoreboard queue.
module tb_ov7670_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vsync, href;
    logic [7:0]  data;
    logic        fsync, tvalid, tlast, tready;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic [31:0] ctrl, bright, contr;

    always #5 clk = ~clk;

    ov7670_capture dut (
        .m_axis_aclk        (clk),
        .m_axis_aresetn     (rst_n),
        .vsync              (vsync),
        .href               (href),
        .data               (data),
        .fsync              (fsync),
        .m_axis_tvalid      (tvalid),
        .m_axis_tdata       (tdata),
        .m_axis_tstrb       (tstrb),
        .m_axis_tlast       (tlast),
        .m_axis_tready      (tready),
        .register_control   (ctrl),
        .register_brightness(bright),
        .register_contrast  (contr)
    );

    typedef struct packed {
        logic [15:0] pixel;
        logic [31:0] control;
        logic [31:0] brightness;
        logic [31:0] contrast;
        logic [31:0] exp_proc;
        logic [31:0] exp_pass;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          beats    = 0;
    logic [32:0] sb_q[$];
    logic [7:0]  line_q[$];
    logic [32:0] mon_prev = '0;
    bit          mon_stalled = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] expand_rgb(input logic [15:0] p);
        logic [4:0] r5;
        logic [5:0] g6;
        logic [4:0] b5;
        r5 = p[15:11];
        g6 = p[10:5];
        b5 = p[4:0];
        return {8'h00, r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
    endfunction

    task automatic add_pixel(input logic [15:0] px);
        line_q.push_back(px[15:8]);
        line_q.push_back(px[7:0]);
    endtask

    task automatic send_line();
        href = 1'b1;
        foreach (line_q[i]) begin
            data = line_q[i];
            tick();
        end
        href = 1'b0;
        data = 8'h00;
        tick(4);
    endtask

    task automatic frame_start();
        vsync = 1'b1;
        tick(2);
        vsync = 1'b0;
        tick(2);
    endtask

    task automatic wait_drain();
        int budget = 0;
        while (sb_q.size() != 0 && budget < 200) begin
            tick();
            budget++;
        end
        check("drain", sb_q.size(), 0);
        tick(6);
    endtask

    // Output monitor: samples just before each rising edge, when inputs and outputs are settled.
    initial begin
        logic [32:0] exp_beat;
        forever begin
            @(negedge clk);
            #4;
            if (mon_stalled) begin
                check("hold_stable", {tvalid, tlast, tdata}, {1'b1, mon_prev});
            end
            if (tvalid && tready && rst_n) begin
                beats++;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got tlast=%0b tdata=0x%08h, expected no beat", tlast, tdata);
                end else begin
                    exp_beat = sb_q.pop_front();
                    check("beat", {tlast, tdata}, exp_beat);
                end
            end
            mon_stalled = tvalid && !tready && rst_n;
            mon_prev    = {tlast, tdata};
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[10];
        logic [31:0] exp_px;
        logic [15:0] px;
        int          fs_count, fs_at, lat, beats_before;

        vecs[0] = '{16'hF800, 32'h01,       32'h0,        32'd16,       32'h00FF0000, 32'h00FF0000};
        vecs[1] = '{16'hFFFF, 32'h21,       32'hFFFFFFFB, 32'd16,       32'h00FAFAFA, 32'h00FFFFFF};
        vecs[2] = '{16'h0000, 32'h21,       32'hFFFFFFFB, 32'd16,       32'h00000000, 32'h00000000};
        vecs[3] = '{16'h8410, 32'h21,       32'h0,        32'd8,        32'h00424142, 32'h00848284};
        vecs[4] = '{16'h07E0, 32'h01,       32'h0,        32'd16,       32'h0000FF00, 32'h0000FF00};
        vecs[5] = '{16'h001F, 32'h21,       32'h64,       32'd32,       32'h006464FF, 32'h000000FF};
        vecs[6] = '{16'h8410, 32'h21,       32'hFF,       32'd0,        32'h00FFFFFF, 32'h00848284};
        vecs[7] = '{16'h8410, 32'h21,       32'hFFFFFF00, 32'd32,       32'h00080408, 32'h00848284};
        vecs[8] = '{16'h8410, 32'h21,       32'h200,      32'h110,      32'h00848284, 32'h00848284};
        vecs[9] = '{16'h1234, 32'hFFFFFFDF, 32'h7F,       32'd3,        32'h001045A5, 32'h001045A5};

        rst_n  = 1'b0;
        vsync  = 1'b0;
        href   = 1'b0;
        data   = 8'h00;
        tready = 1'b1;
        ctrl   = 32'h1;
        bright = 32'h0;
        contr  = 32'd16;

        // Reset held with toggling camera inputs: outputs must stay cleared.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("reset_outputs", {fsync, tvalid, tlast, tdata, tstrb}, {3'b000, 32'h0, 4'hF});
            vsync = ~vsync;
            href  = ~href;
            data  = data + 8'h35;
        end
        vsync = 1'b0;
        href  = 1'b0;
        data  = 8'h00;
        tick();
        rst_n = 1'b1;
        tick(3);

        // Frame start: one fsync pulse, two clocks after vsync is driven high.
        vsync    = 1'b1;
        fs_count = 0;
        fs_at    = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (fsync) begin
                fs_count++;
                if (fs_at == 0) fs_at = i;
            end
        end
        vsync = 1'b0;
        check("fsync_pulses", fs_count, 1);
        check("fsync_cycle", fs_at, 2);
        tick(3);

        // Single-pixel line and second-byte-to-tvalid latency.
        sb_q.push_back({1'b1, 32'h00FF0000});
        href = 1'b1;
        data = 8'hF8;
        tick();
        data = 8'h00;
        tick();
        href = 1'b0;
        data = 8'h00;
        lat  = 1;
        while (!tvalid && lat < 20) begin
            tick();
            lat++;
        end
        check("latency", lat, 4);
        wait_drain();

        // Vector table: one pixel per line, ends with tlast=1.
        for (int i = 0; i < 10; i++) begin
            ctrl   = vecs[i].control;
            bright = vecs[i].brightness;
            contr  = vecs[i].contrast;
`ifdef OV7670_CAPTURE_PROC_EN
            exp_px = vecs[i].exp_proc;
`else
            exp_px = vecs[i].exp_pass;
`endif
            sb_q.push_back({1'b1, exp_px});
            line_q.delete();
            add_pixel(vecs[i].pixel);
            send_line();
            wait_drain();
        end
        ctrl   = 32'h1;
        bright = 32'h0;
        contr  = 32'd16;

        // Trailing odd byte is discarded.
        sb_q.push_back({1'b1, 32'h00FF0000});
        line_q.delete();
        add_pixel(16'hF800);
        line_q.push_back(8'hAB);
        send_line();
        wait_drain();

        // Two pixels: last completion coincides with href fall.
        sb_q.push_back({1'b0, 32'h00FFFFFF});
        sb_q.push_back({1'b1, 32'h00000000});
        line_q.delete();
        add_pixel(16'hFFFF);
        add_pixel(16'h0000);
        send_line();
        wait_drain();

        // Capture disabled at frame start; enabling mid-frame waits for the next frame.
        ctrl = 32'h0;
        frame_start();
        beats_before = beats;
        line_q.delete();
        add_pixel(16'hF800);
        add_pixel(16'h07E0);
        send_line();
        ctrl = 32'h1;
        send_line();
        tick(10);
        check("disabled_beats", beats - beats_before, 0);
        frame_start();
        sb_q.push_back({1'b0, 32'h00FF0000});
        sb_q.push_back({1'b1, 32'h0000FF00});
        send_line();
        wait_drain();

        // Reset mid-line discards pending pixels; capture waits for vsync.
        tready       = 1'b0;
        beats_before = beats;
        href         = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data = 8'(8'hF0 + i);
            tick();
        end
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data = 8'(i);
            tick();
        end
        href = 1'b0;
        data = 8'h00;
        tick(4);
        check("reset_tvalid", tvalid, 0);
        tready = 1'b1;
        line_q.delete();
        add_pixel(16'hF800);
        send_line();
        tick(10);
        check("reset_no_capture", beats - beats_before, 0);
        frame_start();
        sb_q.push_back({1'b1, 32'h00FF0000});
        send_line();
        wait_drain();

        // Backpressure: 16-pixel line with tready low keeps only the first four pixels.
        tready = 1'b0;
        line_q.delete();
        for (int i = 0; i < 16; i++) begin
            px = 16'($urandom);
            add_pixel(px);
            if (i < 4) sb_q.push_back({1'b0, expand_rgb(px)});
        end
        send_line();
        tick(10);
        check("bp_tvalid", tvalid, 1);
        check("bp_pending", sb_q.size(), 4);
        beats_before = beats;
        tready = 1'b1;
        wait_drain();
        check("bp_beats", beats - beats_before, 4);

        // Ten full 640-byte lines at full throughput.
        beats_before = beats;
        for (int l = 0; l < 10; l++) begin
            line_q.delete();
            for (int p = 0; p < 320; p++) begin
                px = 16'($urandom);
                add_pixel(px);
                sb_q.push_back({1'(p == 319), expand_rgb(px)});
            end
            send_line();
        end
        wait_drain();
        check("frame_beats", beats - beats_before, 3200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ov7670_capture.md
OV7670_CAPTURE -- requirements
Module: ov7670_capture

Interface
REQ-001 SHALL have these ports; m_axis_aclk is the single clock for all logic, and m_axis_aresetn is a synchronous, active-low reset:
  m_axis_aclk  in  1  clock; camera signals are synchronous to it.
  m_axis_aresetn  in  1  synchronous active-low reset.
  vsync  in  1  camera frame sync, active high.
  href  in  1  camera line valid, active high.
  data  in  8  camera byte, RGB565, high byte first.
  fsync  out  1  one-cycle frame-start pulse.
  m_axis_tvalid  out  1  AXI-Stream valid.
  m_axis_tdata  out  32  pixel {8'h00, R8, G8, B8}.
  m_axis_tstrb  out  4  always 4'hF.
  m_axis_tlast  out  1  last pixel of a line.
  m_axis_tready  in  1  AXI-Stream ready.
  register_control  in  32  bit0 capture enable; bit5 processing enable; other bits ignored.
  register_brightness  in  32  signed offset; bits [8:0] used as a two's-complement value, -256..255.
  register_contrast  in  32  unsigned gain in bits [7:0], Q4.4 format (16 = 1.0).

Function
REQ-002 SHALL register vsync, href and data once on input; all later logic SHALL use only the registered copies.
REQ-003 SHALL assert fsync for exactly one clock, on the cycle after registered vsync goes 0->1.
REQ-004 SHALL reset the byte phase to "first byte" on registered vsync rising and on every registered href rising.
REQ-005 With registered href=1, each cycle's byte SHALL alternate between first and second byte.
  - First byte = {R5, G6[5:3]}.
  - Second byte = {G6[2:0], B5}.
  - A pixel is complete on each second byte.
REQ-006 A trailing odd byte at href fall SHALL be discarded.
REQ-007 Channel expansion SHALL be: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
REQ-008 With control bit5=1, each 8-bit channel c SHALL be transformed as: y = ((c*contrast[7:0])>>4) + brightness[8:0] (signed).
  - Computed in at least 17-bit signed arithmetic.
  - Result saturated to 0..255.
  - The transform SHALL be a single pipeline register stage.
REQ-009 With control bit5=0, expanded channels SHALL pass through unmodified; pipeline latency SHALL be identical in both modes.
REQ-010 Pixels SHALL be produced only while control bit0=1.
  - Bit0 is sampled at each registered vsync rising; a change mid-frame takes effect at the next frame.
REQ-011 Each processed pixel SHALL be held in a one-pixel hold register and released to the output FIFO when one of two events occurs:
  - The next pixel completes: released with tlast=0.
  - Registered href falls: released with tlast=1.
REQ-012 When pixel completion and href fall occur on the same cycle, the earlier pixel SHALL go first with tlast=0; the new pixel SHALL follow next cycle with tlast=1.
REQ-013 Output SHALL go through a 4-entry FIFO of {tlast, tdata}.
  - A beat transfers when tvalid && tready.
  - tvalid = FIFO not empty.
  - tdata/tlast SHALL be stable while tvalid && !tready.
REQ-014 A pixel arriving when the FIFO is full SHALL be dropped without disturbing stored entries; simultaneous push and pop on a full FIFO SHALL succeed.
REQ-015 Latency from the second byte on the data pin to tvalid, with tready=1 and the release event already pending, SHALL be 4 clocks.
REQ-016 m_axis_tstrb SHALL be constant 4'hF.

Reset
REQ-017 While m_axis_aresetn=0 at a clock edge, the following SHALL be cleared:
  - fsync=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
  - FIFO empty, hold register empty, byte phase = first byte.
  - Input registers = 0.
  - Sampled capture enable = 0.
REQ-018 Reset mid-line SHALL discard all pending pixels; capture SHALL resume only after the next vsync rising.

Configuration
REQ-019 Macro OV7670_CAPTURE_PROC_EN:
  - Defined: REQ-008/009 apply.
  - Undefined: the transform is not compiled, control bit5, register_brightness and register_contrast are ignored, and pixels always pass through with the same latency.

Verification
REQ-020 Reset held 10 clocks -> all outputs 0 (tstrb=4'hF) throughout; no fsync.
REQ-021 vsync 0->1 held 10 clocks -> fsync high exactly 1 cycle, 2 clocks after vsync first sampled high.
REQ-022 control=0x01, one line of bytes F8,00 -> single beat tdata=0x00FF0000, tlast=1.
REQ-023 control=0x21, contrast=16, brightness=-5:
  - Pixel FFFF -> 0x00FAFAFA.
  - Pixel 0000 -> 0x00000000 (saturation).
  - contrast=8, brightness=0, pixel 8410 -> 0x00424142.
REQ-024 control=0x01, 10 lines of 640 bytes with tready=1 -> 320 beats per line, tlast only on beat 320, total 3200 beats.
REQ-025 tready=0 during a 16-pixel line -> exactly 4 beats retained, all later pixels dropped, tdata held stable until tready=1.
